// File: rtl/instr_mem.sv
// Halfword instruction memory: byte-addressed PC in, registered 16-bit
// instruction out one clock later. One write port for program loading,
// write-first on a same-halfword collision, and a synchronous clear of all contents.
module instr_mem #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 2**(ADDR_WIDTH-1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] pc,
  output logic [DATA_WIDTH-1:0] instruction,
  output logic                  misaligned,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data
);

  localparam int IW = ADDR_WIDTH - 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic                  mis_q, mis_d;

  // Bit 0 of either address only selects a byte, so it never reaches the index.
  logic [IW-1:0] ridx, widx;
  assign ridx = pc[ADDR_WIDTH-1:1];
  assign widx = wr_addr[ADDR_WIDTH-1:1];

  // Next memory image: the current contents with the load port's halfword replaced.
  always_comb begin
    mem_d = mem_q;
    if (wr_en) mem_d[widx] = wr_data;
  end

  // Read path: a same-halfword write is forwarded so the fetch sees the new word.
  always_comb begin
    instr_d = mem_q[ridx];
    if (wr_en && (widx == ridx)) instr_d = wr_data;
    mis_d = pc[0];
  end

  // All state: a reset clears storage and outputs and overrides a pending write.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q   <= '{default: '0};
      instr_q <= '0;
      mis_q   <= 1'b0;
    end else begin
      mem_q   <= mem_d;
      instr_q <= instr_d;
      mis_q   <= mis_d;
    end
  end

  assign instruction = instr_q;
  assign misaligned  = mis_q;

endmodule

// File: tb/tb_instr_mem.sv
// Bench for instr_mem: directed cases followed by random traffic, all checked
// against an array model of the memory and its read/write rules.
module tb_instr_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  pc;
  logic [15:0] instruction;
  logic        misaligned;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [15:0] wr_data;

  int checks = 0;
  int errors = 0;

  logic [15:0] model [128];

  instr_mem dut (
    .clk(clk), .rst(rst), .pc(pc), .instruction(instruction),
    .misaligned(misaligned), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive the inputs, predict from the model, then compare after the edge.
  task automatic step(input string tag, input bit r, input logic [7:0] p,
                      input bit we, input logic [7:0] wa, input logic [15:0] wd);
    logic [15:0] e_instr;
    logic        e_mis;
    rst = r; pc = p; wr_en = we; wr_addr = wa; wr_data = wd;
    if (r) begin
      e_instr = 16'h0;
      e_mis   = 1'b0;
      for (int i = 0; i < 128; i++) model[i] = 16'h0;
    end else begin
      if (we && (wa / 2 == p / 2)) e_instr = wd;
      else                         e_instr = model[p / 2];
      e_mis = p[0];
      if (we) model[wa / 2] = wd;
    end
    @(posedge clk);
    #1;
    chk({tag, "_instr"}, {16'h0, instruction}, {16'h0, e_instr});
    chk({tag, "_mis"}, {31'h0, misaligned}, {31'h0, e_mis});
    rst = 1'b0; wr_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; pc = 8'h10; wr_en = 1'b0; wr_addr = 8'h0; wr_data = 16'h0;

    // Reset held two cycles, then reads everywhere return zero.
    step("reset0", 1, 8'h10, 0, 8'h00, 16'h0);
    step("reset1", 1, 8'h10, 0, 8'h00, 16'h0);
    chk("reset_const", {16'h0, instruction}, 32'h0);
    step("post_rst_00", 0, 8'h00, 0, 8'h00, 16'h0);
    step("post_rst_80", 0, 8'h80, 0, 8'h00, 16'h0);
    step("post_rst_ff", 0, 8'hFF, 0, 8'h00, 16'h0);

    // Load 0xA000+k then sweep the PC by 2.
    for (int k = 0; k <= 8'h31; k++)
      step("load", 0, 8'h40 + 8'(2 * k) + 8'h40, 1, 8'(2 * k), 16'hA000 + 16'(k));
    for (int k = 0; k <= 8'h31; k++) begin
      step("sweep", 0, 8'(2 * k), 0, 8'h00, 16'h0);
      chk("sweep_abs", {16'h0, instruction}, 32'hA000 + 32'(k));
    end

    // Misaligned fetch returns the even halfword.
    step("mis_wr", 0, 8'h00, 1, 8'h04, 16'h1234);
    step("mis_05", 0, 8'h05, 0, 8'h00, 16'h0);
    chk("mis_05_abs", {15'h0, misaligned, instruction}, 32'h0001_1234);
    step("mis_06", 0, 8'h06, 0, 8'h00, 16'h0);

    // Same-halfword write is forwarded.
    step("bypass", 0, 8'h08, 1, 8'h08, 16'hBEEF);
    chk("bypass_abs", {16'h0, instruction}, 32'hBEEF);

    // Different-halfword write leaves the read untouched.
    step("diff_wr", 0, 8'h00, 1, 8'h0A, 16'h1111);
    step("diff_rd", 0, 8'h0A, 1, 8'h0C, 16'h2222);
    chk("diff_rd_abs", {16'h0, instruction}, 32'h1111);
    step("diff_nxt", 0, 8'h0C, 0, 8'h00, 16'h0);
    chk("diff_nxt_abs", {16'h0, instruction}, 32'h2222);

    // Reset beats a simultaneous write.
    step("rst_prio", 1, 8'h20, 1, 8'h20, 16'h5555);
    step("rst_prio_rd", 0, 8'h20, 0, 8'h00, 16'h0);
    chk("rst_prio_abs", {16'h0, instruction}, 32'h0);

    // Top entry then wrap to zero.
    step("wrap_wr", 0, 8'h00, 1, 8'hFE, 16'h7777);
    step("wrap_fe", 0, 8'hFE, 0, 8'h00, 16'h0);
    chk("wrap_fe_abs", {16'h0, instruction}, 32'h7777);
    step("wrap_00", 0, 8'h00, 0, 8'h00, 16'h0);
    chk("wrap_00_abs", {16'h0, instruction}, 32'h0);

    // Random traffic with occasional resets and forced collisions.
    for (int n = 0; n < 600; n++) begin
      logic [7:0] p, wa;
      bit r, we;
      p  = 8'($urandom);
      wa = ($urandom_range(0, 3) == 0) ? (p ^ 8'($urandom_range(0, 1))) : 8'($urandom);
      r  = ($urandom_range(0, 79) == 0);
      we = ($urandom_range(0, 1) == 1);
      step("rand", r, p, we, wa, 16'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
